// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified memory between instruction fetch
// and load/store data. One transaction at a time: arbitrate, issue a strobe,
// wait MEM_LAT cycles, return data with a one-cycle valid pulse.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration on a
// last-granted bit instead of data priority with a starvation guard.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] lat_cnt_q;
  logic       own_d_q;
  logic       err_q;
  logic       we_q;
  logic       favour_if;
  logic       grant_i, grant_d;
  logic       arb_ok;
  logic       d_misalign;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve_q;
`endif

  // Arbitration, ready handshakes and next-state decode
  always_comb begin
    state_d    = state_q;
    arb_ok     = reset_n && ((state_q == IDLE) || (state_q == RESP));
    d_misalign = ((d_size == 2'd1) && d_addr[0]) ||
                 ((d_size == 2'd3) && (d_addr[1:0] != 2'b00));
`ifdef MEM_ARB_RR_EN
    favour_if  = last_d_q;
`else
    favour_if  = (starve_q == STARVE_LIM);
`endif
    grant_i    = arb_ok && if_req && (!d_req || favour_if);
    grant_d    = arb_ok && d_req && !(if_req && favour_if);
    if_ready   = grant_i;
    d_ready    = grant_d;
    case (state_q)
      IDLE, RESP: state_d = (grant_i || grant_d) ? ISSUE : IDLE;
      ISSUE:      state_d = WAIT;
      WAIT:       if (lat_cnt_q == LAT_LAST) state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request latch, memory bus, latency counter and response outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lat_cnt_q <= 3'd0;
      own_d_q   <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_size  <= 2'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= 32'd0;
      d_valid   <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      if_valid <= 1'b0;
      if_rdata <= 32'd0;
      d_valid  <= 1'b0;
      d_rdata  <= 32'd0;
      d_err    <= 1'b0;
      if (grant_i) begin
        own_d_q   <= 1'b0;
        err_q     <= 1'b0;
        we_q      <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'd0;
        mem_size  <= 2'd3;
        mem_re    <= 1'b1;
      end else if (grant_d) begin
        own_d_q   <= 1'b1;
        err_q     <= d_misalign;
        we_q      <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_we ? d_wdata : 32'd0;
        mem_size  <= d_size;
        mem_we    <= d_we && !d_misalign;
        mem_re    <= !d_we && !d_misalign;
      end
      if (state_q == ISSUE)     lat_cnt_q <= 3'd0;
      else if (state_q == WAIT) lat_cnt_q <= lat_cnt_q + 3'd1;
      if ((state_q == WAIT) && (lat_cnt_q == LAT_LAST)) begin
        if (own_d_q) begin
          d_valid <= 1'b1;
          d_err   <= err_q;
          d_rdata <= (err_q || we_q) ? 32'd0 : mem_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-granted bit: after a data grant fetch wins the next tie
  always_ff @(posedge clock) begin
    if (!reset_n)     last_d_q <= 1'b0;
    else if (grant_i) last_d_q <= 1'b0;
    else if (grant_d) last_d_q <= 1'b1;
  end
`else
  // Starvation counter: data grants while fetch waits
  always_ff @(posedge clock) begin
    if (!reset_n)                starve_q <= 4'd0;
    else if (grant_i)            starve_q <= 4'd0;
    else if (grant_d && if_req)  starve_q <= starve_q + 4'd1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=1 instance for fetch/store/load,
// misalignment, arbitration and reset, plus a MEM_LAT=3 instance for
// back-to-back fetch spacing.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] mem_rdata;

  logic        if_ready, if_valid, d_ready, d_valid, d_err, mem_we, mem_re;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;

  logic        b_if_ready, b_if_valid, b_d_ready, b_d_valid, b_d_err, b_mem_we, b_mem_re;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_mem_size;

  int vectors = 0;
  int errs    = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(b_if_ready), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ready(b_d_ready), .d_valid(b_d_valid), .d_rdata(b_d_rdata), .d_err(b_d_err),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_size(b_mem_size),
    .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One data transaction from IDLE with MEM_LAT=1: grant T, strobe T+1, valid T+3
  task automatic data_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic [31:0] rd, input logic exp_err);
    logic        exp_re, exp_we;
    logic [31:0] exp_rd;
    exp_re = !we && !exp_err;
    exp_we = we && !exp_err;
    exp_rd = (we || exp_err) ? 32'd0 : rd;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size;
    #1;
    chk({tag, ".d_ready"}, d_ready, 1);
    chk({tag, ".if_ready"}, if_ready, 0);
    tick();
    d_req = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    chk({tag, ".mem_re"}, mem_re, exp_re);
    chk({tag, ".mem_we"}, mem_we, exp_we);
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".mem_size"}, mem_size, size);
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    tick();
    mem_rdata = rd;
    chk({tag, ".strobe_off"}, {mem_re, mem_we}, 0);
    chk({tag, ".early_valid"}, d_valid, 0);
    tick();
    mem_rdata = 32'd0;
    chk({tag, ".d_valid"}, d_valid, 1);
    chk({tag, ".d_err"}, d_err, exp_err);
    chk({tag, ".d_rdata"}, d_rdata, exp_rd);
    chk({tag, ".if_valid"}, if_valid, 0);
    tick();
    chk({tag, ".valid_pulse"}, d_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_i, prev_i;
    // Reset with requests pending: nothing may be granted or driven
    reset_n = 1'b0; if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'd3; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst.if_ready", if_ready, 0);
    chk("rst.d_ready", d_ready, 0);
    chk("rst.strobes", {mem_re, mem_we}, 0);
    chk("rst.valids", {if_valid, d_valid, d_err}, 0);
    chk("rst.mem_addr", mem_addr, 0);
    if_req = 1'b0; d_req = 1'b0; reset_n = 1'b1;
    tick();

    // Single fetch
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("fetch.if_ready", if_ready, 1);
    chk("fetch.d_ready", d_ready, 0);
    tick();
    if_req = 1'b0; mem_rdata = 32'hBAD0BAD0;
    chk("fetch.mem_re", mem_re, 1);
    chk("fetch.mem_we", mem_we, 0);
    chk("fetch.mem_addr", mem_addr, 32'h100);
    chk("fetch.mem_size", mem_size, 3);
    chk("fetch.busy_ready", if_ready, 0);
    tick();
    mem_rdata = 32'h2402000A;
    chk("fetch.re_pulse", mem_re, 0);
    chk("fetch.early_valid", if_valid, 0);
    tick();
    mem_rdata = 32'h0;
    chk("fetch.if_valid", if_valid, 1);
    chk("fetch.if_rdata", if_rdata, 32'h2402000A);
    chk("fetch.d_valid", d_valid, 0);
    tick();
    chk("fetch.valid_pulse", if_valid, 0);

    // Data transactions
    data_txn("store",  1'b1, 32'h40, 32'hDEADBEEF, 2'd3, 32'h12345678, 1'b0);
    data_txn("misld",  1'b0, 32'h42, 32'h0,        2'd3, 32'h12345678, 1'b1);
    data_txn("load",   1'b0, 32'h44, 32'h0,        2'd3, 32'hCAFEF00D, 1'b0);
    data_txn("ldhalf", 1'b0, 32'h42, 32'h0,        2'd1, 32'h0000BEEF, 1'b0);
    data_txn("mishalf",1'b1, 32'h41, 32'h11223344, 2'd1, 32'h0,        1'b1);
    data_txn("unalgn", 1'b0, 32'h43, 32'h0,        2'd2, 32'h00AB00CD, 1'b0);

    // Both ports requesting continuously
    if_req = 1'b1; if_addr = 32'h180;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_size = 2'd3; mem_rdata = 32'h55AA55AA;
    prev_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef MEM_ARB_RR_EN
      exp_i = (k % 2) == 1;
`else
      exp_i = (k % 5) == 4;
`endif
      chk($sformatf("arb%0d.if_ready", k), if_ready, exp_i);
      chk($sformatf("arb%0d.d_ready", k), d_ready, !exp_i);
      if (k > 0) begin
        chk($sformatf("arb%0d.if_valid", k), if_valid, prev_i);
        chk($sformatf("arb%0d.d_valid", k), d_valid, !prev_i);
      end
      prev_i = exp_i;
      tick();
      chk($sformatf("arb%0d.issue_ready", k), {if_ready, d_ready}, 0);
      if (k == 9) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      tick();
      tick();
    end
    #1;
    chk("arb.last_if_valid", if_valid, prev_i);
    chk("arb.last_d_valid", d_valid, !prev_i);
    chk("arb.drained_ready", {if_ready, d_ready}, 0);
    tick();
    mem_rdata = 32'h0;

    // Reset during WAIT of a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_size = 2'd3;
    #1;
    chk("rstw.d_ready", d_ready, 1);
    tick();
    d_req = 1'b0;
    chk("rstw.mem_re", mem_re, 1);
    tick();
    mem_rdata = 32'hFEEDFACE;
    reset_n = 1'b0;
    tick();
    chk("rstw.d_valid", d_valid, 0);
    chk("rstw.strobes", {mem_re, mem_we}, 0);
    chk("rstw.mem_addr", mem_addr, 0);
    chk("rstw.mem_size", mem_size, 0);
    chk("rstw.d_rdata", d_rdata, 0);
    chk("rstw.readies", {if_ready, d_ready, if_valid, d_err}, 0);
    reset_n = 1'b1;
    tick();
    chk("rstw.no_late_valid", d_valid, 0);
    if_req = 1'b1; if_addr = 32'h200;
    #1;
    chk("rstw.post_ready", if_ready, 1);
    tick();
    if_req = 1'b0;
    chk("rstw.post_re", mem_re, 1);
    chk("rstw.post_addr", mem_addr, 32'h200);
    tick();
    mem_rdata = 32'h00C0FFEE;
    tick();
    chk("rstw.post_valid", if_valid, 1);
    chk("rstw.post_rdata", if_rdata, 32'h00C0FFEE);

    // Back-to-back fetches on the MEM_LAT=3 instance
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b0; mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk($sformatf("b2b%0d.if_ready", c), b_if_ready, (c % 5) == 0);
      chk($sformatf("b2b%0d.if_valid", c), b_if_valid, (c >= 5) && ((c % 5) == 0));
      if ((c >= 5) && ((c % 5) == 0))
        chk($sformatf("b2b%0d.if_rdata", c), b_if_rdata, 32'h0BADF00D);
      tick();
    end
    if_req = 1'b0;
    tick(); tick(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
